mdu_ctrl_e: RTL and testbench
=============================

Name: mdu_ctrl_E

Overview:
- Execute-stage multiply/divide sequencer for the P7 MIPS pipeline. It runs alongside the ALU in E.
- It latches operands on a start request, models the multi-cycle latency of mult/div with a counter and state machine, and owns the HI/LO architectural registers.
- It provides the Busy indication that the hazard unit combines with Start to stall mfhi/mflo/mthi/mtlo/mult/div in D.

Parameters:
- MULT_CYCLES, 5, number of cycles Busy stays high for mult/multu (≥1).
- DIV_CYCLES, 10, number of cycles Busy stays high for div/divu (≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Start  input  1  E-stage instruction is mult/multu/div/divu, qualified as valid.
- MDop  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7–15 treated as none.
- SrcA  input  32  rs operand, already forwarded.
- SrcB  input  32  rt operand, already forwarded.
- Req  input  1  exception/interrupt flush of the E instruction; suppresses new Start/mthi/mtlo.
- Busy  output  1  registered; high while an operation is in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (async, any time including mid-operation): state=IDLE, counter=0, Busy=0, HI=0, LO=0. Pending results are discarded.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1, counter counts down, result held in internal temp HI/LO.
- IDLE, Start=1, Req=0, MDop∈{1..4}: at the edge, compute the result into temp registers from the current SrcA/SrcB, load counter with MULT_CYCLES (mult/multu) or DIV_CYCLES (div/divu), go to RUN.
- Result arithmetic:
  - mult: {tempHI,tempLO} = signed 32×32→64.
  - multu: unsigned 32×32→64.
  - div: tempLO = signed quotient truncated toward zero; tempHI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div/divu with SrcB=0: temp = current HI/LO, so HI/LO are left unchanged. Full DIV_CYCLES latency still applies.
- RUN: counter decrements each edge. At the edge where counter==1, HI/LO ← temp and state → IDLE.
  - Busy is high for exactly N cycles after the Start edge.
  - New HI/LO are visible in the first cycle Busy=0.
- mthi/mtlo (MDop 5/6), IDLE, Req=0: HI (or LO) ← SrcA at the edge, visible next cycle. Start is not required.
- Ignored inputs:
  - Start or mthi/mtlo while in RUN: ignored, and no state change occurs. The hazard unit guarantees this does not happen; the bench checks that HI/LO and counter are not corrupted.
  - Req=1 in IDLE: Start and mthi/mtlo are ignored that cycle, and HI/LO are unchanged.
  - Req=1 during RUN: the operation in flight completes normally, because it was committed by an earlier instruction.
  - Start=1 with MDop∉{1..4}: ignored.
- Outputs HI/LO/Busy are register outputs only, with no combinational path from inputs.

Test Plan:
- mult, SrcA=0xFFFFFFFE (−2), SrcB=0x00000003 -> Busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. With multu and the same operands: HI=0x00000002, LO=0xFFFFFFFA.
- div, SrcA=0xFFFFFFF9 (−7), SrcB=2 -> Busy=1 for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. With divu, SrcA=7, SrcB=2: LO=3, HI=1.
- mthi SrcA=0x12345678, then div by SrcB=0 -> Busy=1 for 10 cycles, HI stays 0x12345678 and LO unchanged afterwards. mtlo 0xABCD -> LO=0xABCD next cycle.
- Start=1 with MDop=1 and Req=1 -> Busy stays 0, HI/LO unchanged. Req pulsed during an active mult -> result is still written after 5 cycles.
- Start asserted again with different operands at cycle 2 of a mult -> ignored; final HI/LO equal the first product; Busy falls after 5 cycles total.
- reset asserted asynchronously at cycle 4 of a div -> Busy, HI, LO read 0 immediately, with no clock edge needed; the next mult after reset completes normally.

Source files
------------

// File: rtl/mdu_ctrl_e.sv
// Execute-stage multiply/divide sequencer. It latches operands on a start
// request and computes the result at once. It then holds Busy high for the
// modelled mult/div latency. It owns the architectural HI/LO registers.
module mdu_ctrl_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDop,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        Req,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   count;
  logic [31:0]     temp_hi, temp_lo;
  logic            launch, finish, move_hi, move_lo;
  logic            is_md;
  logic [31:0]     res_hi, res_lo;
  logic [31:0]     divisor;
  logic [63:0]     prod_s, prod_u;
  logic [31:0]     quo_s, rem_s;

  assign is_md = (MDop == OP_MULT) || (MDop == OP_MULTU) ||
                 (MDop == OP_DIV)  || (MDop == OP_DIVU);

  // Busy comes straight from the state flop, so there is no input-to-output path.
  assign Busy = (state == RUN);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and control decode; Req only gates new work, never work in flight.
  // NOTE: every output is defaulted first so no path leaves a value held (no latch).
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    finish     = 1'b0;
    move_hi    = 1'b0;
    move_lo    = 1'b0;
    case (state)
      IDLE: begin
        if (!Req) begin
          if (Start && is_md) begin
            launch     = 1'b1;
            state_next = RUN;
          end else if (MDop == OP_MTHI) begin
            move_hi = 1'b1;
          end else if (MDop == OP_MTLO) begin
            move_lo = 1'b1;
          end
        end
      end
      RUN: begin
        if (count == CW'(1)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Result arithmetic. A zero divisor is replaced by 1 so the divider never
  // sees zero; that result is discarded and HI/LO are carried through instead.
  always_comb begin
    res_hi  = HI;
    res_lo  = LO;
    divisor = (SrcB == 32'd0) ? 32'd1 : SrcB;
    prod_s  = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
    prod_u  = {32'd0, SrcA} * {32'd0, SrcB};
    quo_s   = $signed(SrcA) / $signed(divisor);
    rem_s   = $signed(SrcA) % $signed(divisor);
    case (MDop)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV:   if (SrcB != 32'd0) begin
                  res_lo = quo_s;
                  res_hi = rem_s;
                end
      OP_DIVU:  if (SrcB != 32'd0) begin
                  res_lo = SrcA / divisor;
                  res_hi = SrcA % divisor;
                end
      default: ;
    endcase
  end

  // Latency counter, pending result and architectural HI/LO.
  // NOTE: all of these are few enough to clear on reset, so a pending result is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      temp_hi <= '0;
      temp_lo <= '0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      if (launch) begin
        temp_hi <= res_hi;
        temp_lo <= res_lo;
        count   <= ((MDop == OP_MULT) || (MDop == OP_MULTU)) ? CW'(MULT_CYCLES)
                                                             : CW'(DIV_CYCLES);
      end else if (state == RUN) begin
        count <= count - CW'(1);
      end
      if (finish) begin
        HI <= temp_hi;
        LO <= temp_lo;
      end
      if (move_hi) HI <= SrcA;
      if (move_lo) LO <= SrcA;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl_e.sv
// Self-checking bench for mdu_ctrl_e: directed cases plus randomized
// operations, compared against a value-level model of mult/div and HI/LO.
module tb_mdu_ctrl_e;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MDop;
  logic [31:0] SrcA, SrcB;
  logic        Req;
  logic        Busy;
  logic [31:0] HI, LO;

  int vectors     = 0;
  int miscompares = 0;

  // Architectural HI/LO as the model expects them.
  logic [31:0] m_hi, m_lo;

  mdu_ctrl_e #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDop(MDop),
    .SrcA(SrcA), .SrcB(SrcB), .Req(Req),
    .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    Start = 1'b0; MDop = 4'd0; SrcA = '0; SrcB = '0; Req = 1'b0;
  endtask

  // Model: product/quotient from plain integer arithmetic on magnitudes.
  task automatic ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      ps;
    logic [63:0] pv, ua, ub;
    logic [31:0] ma, mb, q, r;
    sa = a; sb = b;
    case (op)
      4'd1: begin ps = longint'(sa) * longint'(sb); pv = ps; m_hi = pv[63:32]; m_lo = pv[31:0]; end
      4'd2: begin ua = a; ub = b; pv = ua * ub; m_hi = pv[63:32]; m_lo = pv[31:0]; end
      4'd3: if (b != 0) begin
              ma = a[31] ? -a : a;
              mb = b[31] ? -b : b;
              q = ma / mb; r = ma % mb;
              if (a[31] ^ b[31]) q = -q;
              if (a[31]) r = -r;
              m_lo = q; m_hi = r;
            end
      4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      default: ;
    endcase
  endtask

  // Issue one mult/div and follow it for its whole latency. g_kind selects a
  // disturbance in cycle g_cycle: 1 Req pulse, 2 second Start, 3 mthi, 4 mtlo.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int g_cycle, input int g_kind);
    int n;
    n = (op <= 4'd2) ? MULT_N : DIV_N;
    Start = 1'b1; MDop = op; SrcA = a; SrcB = b; Req = 1'b0;
    @(posedge clk); #1;
    idle_inputs();
    ref_op(op, a, b);
    for (int i = 1; i <= n; i++) begin
      check("busy_high", {31'd0, Busy}, 32'd1);
      if (i == g_cycle) begin
        case (g_kind)
          1: Req = 1'b1;
          2: begin Start = 1'b1; MDop = 4'd1; SrcA = $urandom; SrcB = $urandom; end
          3: begin MDop = 4'd5; SrcA = $urandom; end
          4: begin MDop = 4'd6; SrcA = $urandom; end
          default: ;
        endcase
      end
      @(posedge clk); #1;
      idle_inputs();
    end
    check("busy_done", {31'd0, Busy}, 32'd0);
    check("hi_result", HI, m_hi);
    check("lo_result", LO, m_lo);
  endtask

  task automatic do_mt(input logic [3:0] op, input logic [31:0] a, input logic req);
    MDop = op; SrcA = a; Req = req;
    @(posedge clk); #1;
    idle_inputs();
    if (!req) begin
      if (op == 4'd5) m_hi = a;
      if (op == 4'd6) m_lo = a;
    end
    check("mt_busy", {31'd0, Busy}, 32'd0);
    check("mt_hi", HI, m_hi);
    check("mt_lo", LO, m_lo);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    idle_inputs();
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);

    // Directed arithmetic with literal expectations as well.
    run_op(4'd1, 32'hFFFFFFFE, 32'd3, 0, 0);
    check("mult_hi_lit", HI, 32'hFFFFFFFF);
    check("mult_lo_lit", LO, 32'hFFFFFFFA);
    run_op(4'd2, 32'hFFFFFFFE, 32'd3, 0, 0);
    check("multu_hi_lit", HI, 32'h00000002);
    check("multu_lo_lit", LO, 32'hFFFFFFFA);
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 0, 0);
    check("div_lo_lit", LO, 32'hFFFFFFFD);
    check("div_hi_lit", HI, 32'hFFFFFFFF);
    run_op(4'd4, 32'd7, 32'd2, 0, 0);
    check("divu_lo_lit", LO, 32'd3);
    check("divu_hi_lit", HI, 32'd1);

    // Divide by zero leaves HI/LO untouched.
    do_mt(4'd5, 32'h12345678, 1'b0);
    run_op(4'd3, 32'h00000055, 32'd0, 0, 0);
    check("div0_hi_lit", HI, 32'h12345678);
    check("div0_lo_lit", LO, 32'd3);
    run_op(4'd4, 32'hDEADBEEF, 32'd0, 0, 0);
    do_mt(4'd6, 32'h0000ABCD, 1'b0);
    check("mtlo_lit", LO, 32'h0000ABCD);

    // Req suppresses Start and mthi/mtlo in IDLE.
    Start = 1'b1; MDop = 4'd1; SrcA = 32'd9; SrcB = 32'd9; Req = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    check("req_start_busy", {31'd0, Busy}, 32'd0);
    check("req_start_hi", HI, m_hi);
    check("req_start_lo", LO, m_lo);
    do_mt(4'd5, 32'hCAFEF00D, 1'b1);
    do_mt(4'd6, 32'hCAFEF00D, 1'b1);

    // Start with an out-of-range MDop is ignored.
    Start = 1'b1; MDop = 4'd9; SrcA = 32'd5; SrcB = 32'd6;
    @(posedge clk); #1;
    idle_inputs();
    check("bad_op_busy", {31'd0, Busy}, 32'd0);
    check("bad_op_lo", LO, m_lo);

    // Disturbances during RUN must not corrupt the operation in flight.
    run_op(4'd1, 32'h00012345, 32'h00054321, 3, 1);
    run_op(4'd1, 32'h80000001, 32'h7FFFFFFF, 2, 2);
    run_op(4'd3, 32'h80000000, 32'd7, 4, 3);
    run_op(4'd4, 32'hFFFFFFFF, 32'd10, 10, 4);
    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 2);

    // Asynchronous reset in cycle 4 of a divide.
    Start = 1'b1; MDop = 4'd3; SrcA = 32'd1000; SrcB = 32'd3;
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #3;
    check("pre_reset_busy", {31'd0, Busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("areset_busy", {31'd0, Busy}, 32'd0);
    check("areset_hi", HI, 32'd0);
    check("areset_lo", LO, 32'd0);
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("post_reset_busy", {31'd0, Busy}, 32'd0);
    run_op(4'd1, 32'hFFFFFFF0, 32'h00000010, 0, 0);

    // Randomized mix of operations.
    for (int k = 0; k < 30; k++) begin
      op = 4'($urandom_range(1, 6));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 2) == 0) b = b & 32'h0000000F;
      if (op == 4'd3 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      if (op >= 4'd5) do_mt(op, a, 1'($urandom_range(0, 1)));
      else            run_op(op, a, b, int'($urandom_range(0, 10)), int'($urandom_range(0, 4)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
